// File: rtl/jtdd_dwnld_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jtdd_dwnld_pkg
//  Description : Shared memory-map constants, lane masks, FSM state encoding
//                and the pending-write record used by the download router.
//                Region offsets are byte offsets in the ROM file; SDRAM bases
//                are word addresses.
//  Revision    : 1.0 - initial release
// ============================================================================
package jtdd_dwnld_pkg;

    // ROM file byte offsets
    localparam logic [21:0] c_scr_start  = 22'h05_8000;  // scroll ROM, 2 x 64 kB halves
    localparam logic [21:0] c_obj_start  = 22'h07_8000;  // object ROM, 2 x 256 kB halves
    localparam logic [21:0] c_mcu_start  = 22'h0F_8000;  // MCU ROM, 16 kB
    localparam logic [21:0] c_prom_start = 22'h0F_C000;  // priority PROM, 256 B

    // SDRAM word bases
    localparam logic [21:0] c_scr_addr   = 22'h04_0000;
    localparam logic [21:0] c_obj_addr   = 22'h08_0000;
    localparam logic [21:0] c_mcu_addr   = 22'h0C_0000;

    // Active-low byte-lane masks
    localparam logic [1:0]  c_mask_lo    = 2'b10;
    localparam logic [1:0]  c_mask_hi    = 2'b01;
    localparam logic [1:0]  c_mask_none  = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } dwnld_state_t;

    // One pending write. PROM entries carry the PROM address in addr[7:0].
    typedef struct packed {
        logic        is_prom;
        logic [21:0] addr;
        logic [7:0]  data;
        logic [1:0]  mask;
    } wr_entry_t;

    function automatic logic [1:0] lane_mask(input logic sel);
        return sel ? c_mask_hi : c_mask_lo;
    endfunction

endpackage : jtdd_dwnld_pkg
`default_nettype wire

// File: rtl/jtdd_dwnld_remap.sv
`default_nettype none
// ============================================================================
//  Module      : jtdd_dwnld_remap
//  Description : Combinational address remapper. Converts a ROM file byte
//                offset into an SDRAM word address plus byte-lane select, or
//                flags it as a priority-PROM byte or an out-of-range byte.
//  Ports       : ioctl_addr [21:0] in  - byte offset in ROM file
//                word       [21:0] out - SDRAM word address (PROM: [7:0])
//                sel               out - lane select, 0 = low byte
//                is_prom           out - byte belongs to the priority PROM
//                is_drop           out - byte lies beyond the PROM
//  Revision    : 1.0 - initial release
// ============================================================================
module jtdd_dwnld_remap
    import jtdd_dwnld_pkg::*;
#(
    parameter logic [21:0] SCR_START  = c_scr_start,
    parameter logic [21:0] OBJ_START  = c_obj_start,
    parameter logic [21:0] MCU_START  = c_mcu_start,
    parameter logic [21:0] PROM_START = c_prom_start,
    parameter logic [21:0] SCR_ADDR   = c_scr_addr,
    parameter logic [21:0] OBJ_ADDR   = c_obj_addr,
    parameter logic [21:0] MCU_ADDR   = c_mcu_addr
) (
    input  logic [21:0] ioctl_addr,
    output logic [21:0] word,
    output logic        sel,
    output logic        is_prom,
    output logic        is_drop
);

    localparam logic [21:0] c_prom_end = PROM_START + 22'h100;

    // Region-relative offsets, each truncated to the bits its region uses.
    logic [16:0] w_scr_off;
    logic [18:0] w_obj_off;
    logic [13:0] w_mcu_off;
    logic [7:0]  w_prom_off;

    assign w_scr_off  = 17'(ioctl_addr - SCR_START);
    assign w_obj_off  = 19'(ioctl_addr - OBJ_START);
    assign w_mcu_off  = 14'(ioctl_addr - MCU_START);
    assign w_prom_off = 8'(ioctl_addr - PROM_START);

    always_comb begin
        word    = '0;
        sel     = 1'b0;
        is_prom = 1'b0;
        is_drop = 1'b0;
        if (ioctl_addr < SCR_START) begin
            // Linear regions: consecutive bytes fill one word
            word = {1'b0, ioctl_addr[21:1]};
            sel  = ioctl_addr[0];
        end else if (ioctl_addr < OBJ_START) begin
            // Second half of the scroll ROM lands in the high lane of the
            // same word as the first half.
            word = SCR_ADDR + {6'd0, w_scr_off[15:0]};
            sel  = w_scr_off[16];
        end else if (ioctl_addr < MCU_START) begin
            word = OBJ_ADDR + {4'd0, w_obj_off[17:0]};
            sel  = w_obj_off[18];
        end else if (ioctl_addr < PROM_START) begin
            word = MCU_ADDR + {9'd0, w_mcu_off[13:1]};
            sel  = w_mcu_off[0];
        end else if (ioctl_addr < c_prom_end) begin
            word    = {14'd0, w_prom_off};
            is_prom = 1'b1;
        end else begin
            is_drop = 1'b1;
        end
    end

endmodule : jtdd_dwnld_remap
`default_nettype wire

// File: rtl/jtdd_dwnld.sv
`default_nettype none
// ============================================================================
//  Module      : jtdd_dwnld
//  Description : Download router. Turns the ioctl byte stream into SDRAM word
//                writes (prog_*) held until prog_rdy, and priority-PROM
//                strobes (prom_we). A one-deep skid buffer absorbs a byte
//                arriving while an SDRAM write is outstanding; further bytes
//                are dropped and counted.
//  Ports       : clk, rst_n                 - clock, async active-low reset
//                downloading, ioctl_addr,
//                ioctl_data, ioctl_wr       - download byte stream
//                prog_addr/data/mask/we     - SDRAM write request
//                prog_rdy                   - SDRAM write-done pulse
//                prom_we                    - PROM write strobe
//                dwnld_busy                 - download or writes pending
//                drop_cnt                   - saturating discarded-byte count
//  Revision    : 1.0 - initial release
// ============================================================================
module jtdd_dwnld
    import jtdd_dwnld_pkg::*;
#(
    parameter logic [21:0] SCR_START  = c_scr_start,
    parameter logic [21:0] OBJ_START  = c_obj_start,
    parameter logic [21:0] MCU_START  = c_mcu_start,
    parameter logic [21:0] PROM_START = c_prom_start,
    parameter logic [21:0] SCR_ADDR   = c_scr_addr,
    parameter logic [21:0] OBJ_ADDR   = c_obj_addr,
    parameter logic [21:0] MCU_ADDR   = c_mcu_addr
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        downloading,
    input  logic [21:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    output logic [21:0] prog_addr,
    output logic [7:0]  prog_data,
    output logic [1:0]  prog_mask,
    output logic        prog_we,
    input  logic        prog_rdy,
    output logic        prom_we,
    output logic        dwnld_busy,
    output logic [7:0]  drop_cnt
);

    // ------------------------------------------------------------------
    // Address remap
    // ------------------------------------------------------------------
    logic [21:0] w_word;
    logic        w_sel;
    logic        w_is_prom;
    logic        w_is_drop;

    jtdd_dwnld_remap #(
        .SCR_START  (SCR_START),
        .OBJ_START  (OBJ_START),
        .MCU_START  (MCU_START),
        .PROM_START (PROM_START),
        .SCR_ADDR   (SCR_ADDR),
        .OBJ_ADDR   (OBJ_ADDR),
        .MCU_ADDR   (MCU_ADDR)
    ) u_remap (
        .ioctl_addr (ioctl_addr),
        .word       (w_word),
        .sel        (w_sel),
        .is_prom    (w_is_prom),
        .is_drop    (w_is_drop)
    );

    // Incoming byte packaged as a write record
    wr_entry_t w_in;
    always_comb begin
        w_in.is_prom = w_is_prom;
        w_in.addr    = w_word;
        w_in.data    = ioctl_data;
        w_in.mask    = w_is_prom ? c_mask_none : lane_mask(w_sel);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    dwnld_state_t r_state;
    dwnld_state_t w_state_nxt;

    logic [21:0]  r_prog_addr;
    logic [7:0]   r_prog_data;
    logic [1:0]   r_prog_mask;
    logic         r_prog_we;
    logic         r_prom_we;
    wr_entry_t    r_skid;
    logic         r_skid_vld;
    logic [7:0]   r_drop_cnt;

    // Control decoded each cycle
    logic w_strobe;       // qualified byte strobe
    logic w_take;         // strobe for a byte that has somewhere to go
    logic w_prog_we_nxt;
    logic w_issue;        // load prog_addr/data/mask this cycle
    logic w_issue_skid;   // ... from the skid rather than the input
    logic w_prom_pulse;
    logic w_skid_load;
    logic w_skid_pop;
    logic w_drop;

    assign w_strobe = ioctl_wr & downloading;
    assign w_take   = w_strobe & ~w_is_drop;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_prog_we_nxt = r_prog_we;
        w_issue       = 1'b0;
        w_issue_skid  = 1'b0;
        w_prom_pulse  = 1'b0;
        w_skid_load   = 1'b0;
        w_skid_pop    = 1'b0;
        w_drop        = w_strobe & w_is_drop;

        case (r_state)
            ST_IDLE: begin
                // prog_rdy is meaningless here and ignored
                if (w_take) begin
                    w_issue = 1'b1;
                    if (w_is_prom) begin
                        w_prom_pulse = 1'b1;
                    end else begin
                        w_prog_we_nxt = 1'b1;
                        w_state_nxt   = ST_BUSY;
                    end
                end
            end

            ST_BUSY: begin
                if (r_prog_we) begin
                    // Request outstanding: prog_addr/data/mask must not move,
                    // so PROM bytes queue in the skid too.
                    if (w_take) begin
                        if (!r_skid_vld) begin
                            w_skid_load = 1'b1;
                        end else begin
                            w_drop = 1'b1;
                        end
                    end
                    if (prog_rdy) begin
                        w_prog_we_nxt = 1'b0;
                        if (!(r_skid_vld || w_skid_load)) begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end else begin
                    // Gap cycle after an acknowledge: drain the skid. It
                    // frees up this same cycle, so a new byte can refill it.
                    if (w_take) begin
                        w_skid_load = 1'b1;
                    end
                    if (r_skid_vld) begin
                        w_skid_pop   = 1'b1;
                        w_issue      = 1'b1;
                        w_issue_skid = 1'b1;
                        if (r_skid.is_prom) begin
                            w_prom_pulse = 1'b1;
                        end else begin
                            w_prog_we_nxt = 1'b1;
                        end
                    end
                    if ((!r_skid_vld || r_skid.is_prom) && !w_skid_load) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt   = ST_IDLE;
                w_prog_we_nxt = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: output capture, skid buffer, drop counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prog_addr <= '0;
            r_prog_data <= '0;
            r_prog_mask <= c_mask_none;
            r_prog_we   <= 1'b0;
            r_prom_we   <= 1'b0;
            r_skid      <= '0;
            r_skid_vld  <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            r_prog_we <= w_prog_we_nxt;
            r_prom_we <= w_prom_pulse;

            if (w_issue) begin
                if (w_issue_skid) begin
                    r_prog_addr <= r_skid.addr;
                    r_prog_data <= r_skid.data;
                    r_prog_mask <= r_skid.mask;
                end else begin
                    r_prog_addr <= w_in.addr;
                    r_prog_data <= w_in.data;
                    r_prog_mask <= w_in.mask;
                end
            end

            if (w_skid_load) begin
                r_skid     <= w_in;
                r_skid_vld <= 1'b1;
            end else if (w_skid_pop) begin
                r_skid_vld <= 1'b0;
            end

            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign prog_addr  = r_prog_addr;
    assign prog_data  = r_prog_data;
    assign prog_mask  = r_prog_mask;
    assign prog_we    = r_prog_we;
    assign prom_we    = r_prom_we;
    assign drop_cnt   = r_drop_cnt;
    assign dwnld_busy = downloading | (r_state == ST_BUSY) | r_skid_vld;

endmodule : jtdd_dwnld
`default_nettype wire

// File: tb/tb_jtdd_dwnld.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jtdd_dwnld
//  Description : Directed self-checking bench for jtdd_dwnld. Inputs change
//                and outputs are sampled on the falling clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jtdd_dwnld;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        downloading = 1'b0;
    logic [21:0] ioctl_addr = '0;
    logic [7:0]  ioctl_data = '0;
    logic        ioctl_wr = 1'b0;
    logic        prog_rdy = 1'b0;
    logic [21:0] prog_addr;
    logic [7:0]  prog_data;
    logic [1:0]  prog_mask;
    logic        prog_we;
    logic        prom_we;
    logic        dwnld_busy;
    logic [7:0]  drop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    jtdd_dwnld dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .downloading (downloading),
        .ioctl_addr  (ioctl_addr),
        .ioctl_data  (ioctl_data),
        .ioctl_wr    (ioctl_wr),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_mask   (prog_mask),
        .prog_we     (prog_we),
        .prog_rdy    (prog_rdy),
        .prom_we     (prom_we),
        .dwnld_busy  (dwnld_busy),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge, by which
    // time the DUT has registered the byte.
    task automatic send(input logic [21:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        @(negedge clk);
        ioctl_wr   = 1'b0;
    endtask

    task automatic ack();
        prog_rdy = 1'b1;
        @(negedge clk);
        prog_rdy = 1'b0;
    endtask

    task automatic expect_wr(input string tag, input logic [21:0] a,
                             input logic [1:0] m, input logic [7:0] d);
        check({tag, " we"},   prog_we,   1);
        check({tag, " addr"}, prog_addr, a);
        check({tag, " mask"}, prog_mask, m);
        check({tag, " data"}, prog_data, d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        // Reset state
        check("rst prog_we",   prog_we,    0);
        check("rst prog_mask", prog_mask,  2'b11);
        check("rst prog_addr", prog_addr,  0);
        check("rst prog_data", prog_data,  0);
        check("rst prom_we",   prom_we,    0);
        check("rst drop_cnt",  drop_cnt,   0);
        check("rst busy",      dwnld_busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        downloading = 1'b1;
        @(negedge clk);
        check("busy while downloading", dwnld_busy, 1);

        // Linear region, odd byte -> high lane, held until prog_rdy
        send(22'h0_0001, 8'hA5);
        expect_wr("lin", 22'h0_0000, 2'b01, 8'hA5);
        repeat (4) @(negedge clk);
        check("lin held we",   prog_we,   1);
        check("lin held addr", prog_addr, 22'h0_0000);
        ack();
        check("lin released", prog_we, 0);

        // Scroll halves interleave into one word
        send(22'h5_8010, 8'h11);
        expect_wr("scr lo", 22'h4_0010, 2'b10, 8'h11);
        ack();
        send(22'h6_8010, 8'h22);
        expect_wr("scr hi", 22'h4_0010, 2'b01, 8'h22);
        ack();

        // Object and MCU regions
        send(22'hB_8004, 8'h33);
        expect_wr("obj", 22'h8_0004, 2'b01, 8'h33);
        ack();
        send(22'hF_8003, 8'h44);
        expect_wr("mcu", 22'hC_0001, 2'b01, 8'h44);
        ack();

        // PROM byte: single prom_we pulse, no SDRAM request
        send(22'hF_C07F, 8'h0C);
        check("prom we",      prom_we,        1);
        check("prom addr",    prog_addr[7:0], 8'h7F);
        check("prom data",    prog_data,      8'h0C);
        check("prom prog_we", prog_we,        0);
        @(negedge clk);
        check("prom pulse end", prom_we, 0);

        // Three strobes while prog_rdy withheld
        send(22'h0_0010, 8'h51);
        expect_wr("ovf 1st", 22'h0_0008, 2'b10, 8'h51);
        send(22'h0_0012, 8'h52);
        send(22'h0_0014, 8'h53);
        check("ovf drop_cnt", drop_cnt,  1);
        check("ovf stable",   prog_addr, 22'h0_0008);
        downloading = 1'b0;
        @(negedge clk);
        check("drain busy a", dwnld_busy, 1);
        ack();
        check("gap we",        prog_we,    0);
        check("drain busy b",  dwnld_busy, 1);
        @(negedge clk);
        expect_wr("ovf 2nd", 22'h0_0009, 2'b10, 8'h52);
        @(negedge clk);
        check("drain busy c", dwnld_busy, 1);
        ack();
        check("drained we",   prog_we,    0);
        check("drained busy", dwnld_busy, 0);
        repeat (2) @(negedge clk);
        check("3rd never issued", prog_we, 0);

        // Out-of-range byte
        downloading = 1'b1;
        send(22'hF_C100, 8'h66);
        check("oor drop_cnt", drop_cnt, 2);
        check("oor prog_we",  prog_we,  0);
        check("oor prom_we",  prom_we,  0);

        // Strobe ignored when not downloading; prog_rdy in IDLE ignored
        downloading = 1'b0;
        send(22'h0_0020, 8'h77);
        check("nodl prog_we", prog_we,  0);
        check("nodl drop",    drop_cnt, 2);
        ack();
        check("idle rdy", prog_we, 0);

        // prog_rdy coincident with a new strobe
        downloading = 1'b1;
        send(22'h0_0030, 8'h81);
        expect_wr("coin 1st", 22'h0_0018, 2'b10, 8'h81);
        ioctl_addr = 22'h0_0033;
        ioctl_data = 8'h82;
        ioctl_wr   = 1'b1;
        prog_rdy   = 1'b1;
        @(negedge clk);
        ioctl_wr   = 1'b0;
        prog_rdy   = 1'b0;
        check("coin gap", prog_we, 0);
        @(negedge clk);
        expect_wr("coin 2nd", 22'h0_0019, 2'b01, 8'h82);
        check("coin drop", drop_cnt, 2);
        ack();

        // Reset mid-write with skid full
        send(22'h0_0040, 8'h91);
        send(22'h0_0042, 8'h92);
        check("pre-rst we", prog_we, 1);
        rst_n = 1'b0;
        #1;
        check("mid-rst we",   prog_we,   0);
        check("mid-rst mask", prog_mask, 2'b11);
        check("mid-rst addr", prog_addr, 0);
        check("mid-rst drop", drop_cnt,  0);
        downloading = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-rst busy", dwnld_busy, 0);
        ack();
        @(negedge clk);
        check("skid lost", prog_we, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_jtdd_dwnld
`default_nettype wire
